// File: rtl/alu_operand_sequencer_pkg.sv
// Shared constants and types for the ALU operand sequencer.
package alu_operand_sequencer_pkg;

    localparam int unsigned DEFAULT_DATA_W          = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int unsigned PHASE_W                 = 3;
    localparam int unsigned SEL_W                   = 2;

    // Sequencer states; the encoding is also shown on the status LEDs
    typedef enum logic [PHASE_W-1:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4
    } phaseT;

    // ALU select codes {S1,S0}
    localparam logic [SEL_W-1:0] OP_ADD = 2'b00;
    localparam logic [SEL_W-1:0] OP_SUB = 2'b01;
    localparam logic [SEL_W-1:0] OP_AND = 2'b10;
    localparam logic [SEL_W-1:0] OP_XOR = 2'b11;

endpackage

// File: rtl/alu_operand_sequencer_btn.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       syncQ;
    logic             syncLevel;
    logic [CNT_W-1:0] stableCnt;

    assign syncLevel = syncQ[1];

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            syncQ <= 2'b00;
        end else begin
            syncQ <= {syncQ[0], btn_raw};
        end
    end

    // Accept a level change only after it has persisted; pulse on accepted press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= 1'b0;
            stableCnt  <= '0;
            rise_pulse <= 1'b0;
        end else begin
            rise_pulse <= 1'b0;
            if (syncLevel == level) begin
                stableCnt <= '0;
            end else if (stableCnt == CNT_LAST) begin
                level      <= syncLevel;
                stableCnt  <= '0;
                rise_pulse <= syncLevel;
            end else begin
                stableCnt <= stableCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and opcode from the switches, drives the ALU, latches its result.
module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W          = DEFAULT_DATA_W,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw,
    input  logic              btn_load,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [1:0]        op_sel,
    input  logic [DATA_W-1:0] alu_r,
    input  logic              alu_cout,
    input  logic              alu_ovr,
    output logic [DATA_W-1:0] res_q,
    output logic              cout_q,
    output logic              ovr_q,
    output logic              res_valid,
    output logic [2:0]        phase
);

    logic loadEvt;
    logic clearEvt;

    phaseT             stateQ;
    phaseT             stateNext;
    logic [DATA_W-1:0] opANext;
    logic [DATA_W-1:0] opBNext;
    logic [SEL_W-1:0]  opSelNext;
    logic [DATA_W-1:0] resNext;
    logic              coutNext;
    logic              ovrNext;
    logic              resValidNext;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uLoadBtn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_load),
        .level      (),
        .rise_pulse (loadEvt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) uClearBtn (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_clear),
        .level      (),
        .rise_pulse (clearEvt)
    );

    assign phase = stateQ;

    // Next state and next register contents; clear dominates any load
    always_comb begin
        stateNext    = stateQ;
        opANext      = op_a;
        opBNext      = op_b;
        opSelNext    = op_sel;
        resNext      = res_q;
        coutNext     = cout_q;
        ovrNext      = ovr_q;
        resValidNext = res_valid;
        if (clearEvt) begin
            stateNext    = ST_GET_A;
            opANext      = '0;
            opBNext      = '0;
            opSelNext    = OP_ADD;
            resNext      = '0;
            coutNext     = 1'b0;
            ovrNext      = 1'b0;
            resValidNext = 1'b0;
        end else begin
            case (stateQ)
                ST_GET_A, ST_SHOW: begin
                    if (loadEvt) begin
                        opANext      = sw;
                        resValidNext = 1'b0;
                        stateNext    = ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (loadEvt) begin
                        opBNext   = sw;
                        stateNext = ST_GET_OP;
                    end
                end
                ST_GET_OP: begin
                    if (loadEvt) begin
                        opSelNext = sw[SEL_W-1:0];
                        stateNext = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Operands have been stable for the whole cycle; ALU output has settled
                    resNext      = alu_r;
                    coutNext     = alu_cout;
                    ovrNext      = alu_ovr;
                    resValidNext = 1'b1;
                    stateNext    = ST_SHOW;
                end
                default: begin
                    stateNext = ST_GET_A;
                end
            endcase
        end
    end

    // State, operand and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ    <= ST_GET_A;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            res_q     <= '0;
            cout_q    <= 1'b0;
            ovr_q     <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            stateQ    <= stateNext;
            op_a      <= opANext;
            op_b      <= opBNext;
            op_sel    <= opSelNext;
            res_q     <= resNext;
            cout_q    <= coutNext;
            ovr_q     <= ovrNext;
            res_valid <= resValidNext;
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed self-checking bench for alu_operand_sequencer with a behavioural 4-bit ALU.
module tb_alu_operand_sequencer;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned DEB    = 16;
    localparam int unsigned HOLD   = DEB + 6;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] sw;
    logic              btn_load;
    logic              btn_clear;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        op_sel;
    logic [DATA_W-1:0] alu_r;
    logic              alu_cout;
    logic              alu_ovr;
    logic [DATA_W-1:0] res_q;
    logic              cout_q;
    logic              ovr_q;
    logic              res_valid;
    logic [2:0]        phase;

    int numCompared   = 0;
    int numMismatched = 0;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.DATA_W(DATA_W), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .btn_load  (btn_load),
        .btn_clear (btn_clear),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .alu_r     (alu_r),
        .alu_cout  (alu_cout),
        .alu_ovr   (alu_ovr),
        .res_q     (res_q),
        .cout_q    (cout_q),
        .ovr_q     (ovr_q),
        .res_valid (res_valid),
        .phase     (phase)
    );

    // Behavioural ALU: 00 add, 01 sub (A + ~B + 1), 10 and, 11 xor
    logic [DATA_W:0] aluSum;
    always_comb begin
        aluSum   = '0;
        alu_r    = '0;
        alu_cout = 1'b0;
        alu_ovr  = 1'b0;
        case (op_sel)
            2'b00: begin
                aluSum   = {1'b0, op_a} + {1'b0, op_b};
                alu_r    = aluSum[DATA_W-1:0];
                alu_cout = aluSum[DATA_W];
                alu_ovr  = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (alu_r[DATA_W-1] != op_a[DATA_W-1]);
            end
            2'b01: begin
                aluSum   = {1'b0, op_a} + {1'b0, ~op_b} + (DATA_W+1)'(1);
                alu_r    = aluSum[DATA_W-1:0];
                alu_cout = aluSum[DATA_W];
                alu_ovr  = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (alu_r[DATA_W-1] != op_a[DATA_W-1]);
            end
            2'b10:   alu_r = op_a & op_b;
            default: alu_r = op_a ^ op_b;
        endcase
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numCompared++;
        if (got !== exp) begin
            numMismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkOutputs(input string tag, input int a, input int b, input int sel,
                                input int res, input int co, input int ov, input int vld, input int ph);
        checkVal({tag, ".op_a"},      32'(op_a),      32'(a));
        checkVal({tag, ".op_b"},      32'(op_b),      32'(b));
        checkVal({tag, ".op_sel"},    32'(op_sel),    32'(sel));
        checkVal({tag, ".res_q"},     32'(res_q),     32'(res));
        checkVal({tag, ".cout_q"},    32'(cout_q),    32'(co));
        checkVal({tag, ".ovr_q"},     32'(ovr_q),     32'(ov));
        checkVal({tag, ".res_valid"}, 32'(res_valid), 32'(vld));
        checkVal({tag, ".phase"},     32'(phase),     32'(ph));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pressLoad(input logic [DATA_W-1:0] val);
        sw       = val;
        btn_load = 1'b1;
        repeat (HOLD) tick();
        btn_load = 1'b0;
        repeat (HOLD) tick();
    endtask

    task automatic pressClear();
        btn_clear = 1'b1;
        repeat (HOLD) tick();
        btn_clear = 1'b0;
        repeat (HOLD) tick();
    endtask

    initial begin
        int  waitCyc;
        bit  seen;
        bit  earlyEvt;

        rst_n     = 1'b0;
        sw        = '0;
        btn_load  = 1'b0;
        btn_clear = 1'b0;

        // Reset with noisy inputs
        repeat (10) begin
            tick();
            sw        = DATA_W'($urandom);
            btn_load  = 1'($urandom_range(0, 1));
            btn_clear = 1'($urandom_range(0, 1));
        end
        tick();
        checkOutputs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        rst_n     = 1'b1;
        repeat (50) tick();
        checkOutputs("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // 5 + 3: result 8, signed overflow, no carry
        pressLoad(4'd5);
        checkVal("add.phase_after_a", 32'(phase), 32'd1);
        pressLoad(4'd3);
        pressLoad(4'd0);
        checkOutputs("add", 5, 3, 0, 8, 0, 1, 1, 4);

        // 3 - 5 = 14 (two's complement -2), borrow shows as cout=0
        pressLoad(4'd3);
        pressLoad(4'd5);
        pressLoad(4'd1);
        checkOutputs("sub", 3, 5, 1, 14, 0, 0, 1, 4);

        // Load from SHOW starts a fresh entry; previous result held but invalid
        pressLoad(4'd9);
        checkOutputs("restart", 9, 5, 1, 14, 0, 0, 0, 1);

        // AND with upper switch bits set on the opcode entry: 9 & 12 = 8
        pressLoad(4'd12);
        pressLoad(4'b1110);
        checkOutputs("and", 9, 12, 2, 8, 0, 0, 1, 4);

        // Bouncy press: 3-cycle toggles, then steady high
        sw       = 4'd11;
        earlyEvt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_load = (i % 2 == 0);
            repeat (3) begin
                tick();
                if (phase != 3'd4) earlyEvt = 1'b1;
            end
        end
        btn_load = 1'b1;
        seen     = 1'b0;
        waitCyc  = 0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            tick();
            if (phase != 3'd4) begin
                seen    = 1'b1;
                waitCyc = n;
            end
        end
        checkVal("bounce.no_early_event", 32'(earlyEvt), 32'd0);
        // Pulse fires DEB+2 edges after the final raw edge; phase registers it one edge later
        checkVal("bounce.latency", 32'(waitCyc), 32'(DEB + 3));
        checkVal("bounce.op_a", 32'(op_a), 32'd11);
        repeat (40) tick();
        checkVal("bounce.single_event", 32'(phase), 32'd1);
        btn_load = 1'b0;
        repeat (40) tick();
        checkVal("bounce.release_no_event", 32'(phase), 32'd1);

        // Press shorter than the debounce window
        sw       = 4'd6;
        btn_load = 1'b1;
        repeat (10) tick();
        btn_load = 1'b0;
        repeat (40) tick();
        checkVal("short.phase", 32'(phase), 32'd1);
        checkVal("short.op_b", 32'(op_b), 32'd12);

        // Clear from GET_OP
        pressClear();
        checkOutputs("clear1", 0, 0, 0, 0, 0, 0, 0, 0);
        pressLoad(4'd7);
        pressLoad(4'd2);
        checkVal("pre_clear.phase", 32'(phase), 32'd2);
        checkVal("pre_clear.op_b", 32'(op_b), 32'd2);
        pressClear();
        checkOutputs("clear2", 0, 0, 0, 0, 0, 0, 0, 0);

        // Clear and load accepted on the same cycle
        sw        = 4'hA;
        btn_load  = 1'b1;
        btn_clear = 1'b1;
        repeat (HOLD) tick();
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (HOLD) tick();
        checkVal("clr_vs_load.phase", 32'(phase), 32'd0);
        checkVal("clr_vs_load.op_a", 32'(op_a), 32'd0);

        // Reset during the EXEC cycle aborts the capture
        pressLoad(4'd1);
        pressLoad(4'd2);
        sw       = 4'd3;
        btn_load = 1'b1;
        seen     = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            tick();
            if (phase == 3'd3) seen = 1'b1;
        end
        rst_n    = 1'b0;
        btn_load = 1'b0;
        checkVal("exec.reached", 32'(seen), 32'd1);
        tick();
        checkOutputs("exec_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (5) tick();
        pressLoad(4'd6);
        checkOutputs("after_reset", 6, 0, 0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end

endmodule
